// File: rtl/matrix_arb_pkg.sv
// Shared types and constants for the matrix BRAM read arbiter.
// The requester index field is sized for the largest supported requester count.
package matrix_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } arb_state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } arb_tag_t;

    localparam int TAG_W = $bits(arb_tag_t);

endpackage

// File: rtl/arb_tag_pipe.sv
// Tag shift register that tracks which requester owns each read in flight.
// It is DEPTH stages deep and is cleared asynchronously so that pre-reset reads never complete.
module arb_tag_pipe
    import matrix_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out,
    output logic             inner_valid
);

    arb_tag_t stage [DEPTH];

    // NOTE: every stage is reset, unlike a data RAM, because a stale valid bit would raise a false rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= arb_tag_t'(tag_in);
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

    // Valid bits that are still inside the pipe after the next edge; the last stage shifts out.
    always_comb begin
        inner_valid = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            inner_valid = inner_valid | stage[k].valid;
        end
    end

endmodule

// File: rtl/matrix_bram_read_arbiter.sv
// Round-robin arbiter with lockable ownership for the single read port of the matrix BRAM.
// Optional MATRIX_ARB_STATS_EN adds a saturating conflict_count output.
module matrix_bram_read_arbiter
    import matrix_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          bram_en,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    input  logic [DATA_WIDTH-1:0]         bram_data,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic                          busy
`ifdef MATRIX_ARB_STATS_EN
    ,
    output logic [15:0]                   conflict_count
`endif
);

    arb_state_t       state, next_state;
    logic [IDX_W-1:0] last_gnt;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             owner_hold;
    logic [IDX_W:0]   pick;
    logic [NUM_REQ-1:0] owner_mask;
    logic             pipe_inner_valid;
    logic             busy_next;
    logic [TAG_W-1:0] tag_in, tag_out;
    arb_tag_t         tag_done;

    // Rotate so the index after 'last' sits at bit 0, then take the lowest set bit.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        int                   start;
        int                   p;
        logic                 hit;
        start = int'(last) + 1;
        dbl   = {r, r} >> start;
        rot   = dbl[NUM_REQ-1:0];
        hit   = 1'b0;
        p     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                hit = 1'b1;
                p   = i;
            end
        end
        return {hit, IDX_W'((start + p) % NUM_REQ)};
    endfunction

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        owner_mask = NUM_REQ'(1) << last_gnt;
        owner_hold = (state == ARB_LOCKED) && (|(req & lock & owner_mask));
        pick       = rr_pick(req, last_gnt);
        sel_valid  = pick[IDX_W];
        sel_idx    = pick[IDX_W-1:0];
        // While locked, last_gnt is the owner, so a released lock re-arbitrates starting after it.
        if (owner_hold) begin
            sel_valid = 1'b1;
            sel_idx   = last_gnt;
        end
        gnt        = sel_valid ? (NUM_REQ'(1) << sel_idx) : '0;
        next_state = (sel_valid && (|(lock & gnt))) ? ARB_LOCKED : ARB_OPEN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_OPEN;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt  <= IDX_W'(NUM_REQ - 1);
            bram_en   <= 1'b0;
            bram_addr <= '0;
            busy      <= 1'b0;
        end else begin
            bram_en <= sel_valid;
            busy    <= busy_next;
            if (sel_valid) begin
                bram_addr <= addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                last_gnt  <= sel_idx;
            end
        end
    end

    // The busy flop reflects the in-flight, enable and lock state that holds after the same edge.
    assign busy_next = sel_valid | bram_en | pipe_inner_valid | (next_state == ARB_LOCKED);

    assign tag_in = {bram_en, last_gnt};

    arb_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .tag_in      (tag_in),
        .tag_out     (tag_out),
        .inner_valid (pipe_inner_valid)
    );

    assign tag_done = arb_tag_t'(tag_out);
    assign rvalid   = tag_done.valid ? (NUM_REQ'(1) << tag_done.idx) : '0;
    assign rdata    = bram_data;

`ifdef MATRIX_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_count <= '0;
        end else if (($countones(req) > 1) && (conflict_count != 16'hFFFF)) begin
            conflict_count <= conflict_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_bram_read_arbiter.sv
// Directed bench for matrix_bram_read_arbiter at READ_LATENCY 1 and 3.
// The conflict counter scenario is built only when MATRIX_ARB_STATS_EN is defined.
module tb_matrix_bram_read_arbiter;

    localparam int NR = 4;
    localparam int AW = 14;
    localparam int DW = 32;

    logic           clk;
    logic           rst;

    logic [NR-1:0]    req, lock, gnt, rvalid;
    logic [NR*AW-1:0] addr;
    logic             bram_en, busy;
    logic [AW-1:0]    bram_addr;
    logic [DW-1:0]    bram_data, rdata;

    logic [NR-1:0]    req3, lock3, gnt3, rvalid3;
    logic [NR*AW-1:0] addr3;
    logic             bram_en3, busy3;
    logic [AW-1:0]    bram_addr3;
    logic [DW-1:0]    bram_data3, rdata3, d1, d2;

`ifdef MATRIX_ARB_STATS_EN
    logic [15:0] conflict_count, conflict_count3;
`endif

    int checks = 0;
    int errors = 0;

    matrix_bram_read_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr), .gnt(gnt),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_data(bram_data),
        .rdata(rdata), .rvalid(rvalid), .busy(busy)
`ifdef MATRIX_ARB_STATS_EN
        , .conflict_count(conflict_count)
`endif
    );

    matrix_bram_read_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)
    ) dut3 (
        .clk(clk), .rst(rst), .req(req3), .lock(lock3), .addr(addr3), .gnt(gnt3),
        .bram_en(bram_en3), .bram_addr(bram_addr3), .bram_data(bram_data3),
        .rdata(rdata3), .rvalid(rvalid3), .busy(busy3)
`ifdef MATRIX_ARB_STATS_EN
        , .conflict_count(conflict_count3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM contents: one fixed word at 1152, otherwise a tagged copy of the address.
    function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
        if (a == 14'd1152) return 32'h0303_0000;
        return 32'hA5A5_0000 | {18'd0, a};
    endfunction

    always @(posedge clk) begin
        bram_data <= fdata(bram_addr);
        d1         <= fdata(bram_addr3);
        d2         <= d1;
        bram_data3 <= d2;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        req3 = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        step();
        settle();
        checks++;
        if (bram_en !== 1'b0) begin errors++; $display("FAIL reset_bram_en got %b exp 0", bram_en); end
        checks++;
        if (bram_addr !== '0) begin errors++; $display("FAIL reset_bram_addr got %0d exp 0", bram_addr); end
        checks++;
        if (rvalid !== '0) begin errors++; $display("FAIL reset_rvalid got %b exp 0000", rvalid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL reset_gnt_idle got %b exp 0000", gnt); end
        req = 4'b0110;
        settle();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL reset_gnt_comb got %b exp 0010", gnt); end
        req = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_addr(0, 14'd1152);
        req = 4'b0001;
        settle();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt); end
        step();
        req = '0;
        settle();
        checks++;
        if (bram_en !== 1'b1) begin errors++; $display("FAIL single_bram_en got %b exp 1", bram_en); end
        checks++;
        if (bram_addr !== 14'd1152) begin errors++; $display("FAIL single_bram_addr got %0d exp 1152", bram_addr); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        checks++;
        if (rvalid !== '0) begin errors++; $display("FAIL single_rvalid_early got %b exp 0000", rvalid); end
        step();
        settle();
        checks++;
        if (rvalid !== 4'b0001) begin errors++; $display("FAIL single_rvalid got %b exp 0001", rvalid); end
        checks++;
        if (rdata !== 32'h0303_0000) begin errors++; $display("FAIL single_rdata got %h exp 03030000", rdata); end
        checks++;
        if (bram_en !== 1'b0) begin errors++; $display("FAIL single_bram_en_fall got %b exp 0", bram_en); end
        step();
        settle();
        checks++;
        if (rvalid !== '0) begin errors++; $display("FAIL single_rvalid_pulse got %b exp 0000", rvalid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b exp 0", busy); end
    endtask

    task automatic test_contention();
        logic [NR-1:0] exp_g  [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        logic [AW-1:0] exp_a;
        do_reset();
        set_addr(0, 14'd100);
        set_addr(2, 14'd200);
        for (int i = 0; i < 6; i++) begin
            req = (i < 4) ? 4'b0101 : 4'b0000;
            settle();
            if (i < 4) begin
                checks++;
                if (gnt !== exp_g[i]) begin errors++; $display("FAIL contention_gnt[%0d] got %b exp %b", i, gnt, exp_g[i]); end
            end
            if (i >= 2) begin
                exp_a = (exp_g[i-2] == 4'b0001) ? 14'd100 : 14'd200;
                checks++;
                if (rvalid !== exp_g[i-2]) begin errors++; $display("FAIL contention_rvalid[%0d] got %b exp %b", i, rvalid, exp_g[i-2]); end
                checks++;
                if (rdata !== fdata(exp_a)) begin errors++; $display("FAIL contention_rdata[%0d] got %h exp %h", i, rdata, fdata(exp_a)); end
            end
            step();
        end
    endtask

    task automatic test_lock();
        do_reset();
        set_addr(1, 14'd10);
        set_addr(3, 14'd30);
        for (int i = 0; i < 6; i++) begin
            req  = 4'b1010;
            lock = (i < 5) ? 4'b0010 : 4'b0000;
            settle();
            checks++;
            if (i < 5) begin
                if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_gnt[%0d] got %b exp 0010", i, gnt); end
            end else begin
                if (gnt !== 4'b1000) begin errors++; $display("FAIL lock_release_gnt got %b exp 1000", gnt); end
            end
            if (i == 2) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy got %b exp 1", busy); end
            end
            step();
        end
        req  = '0;
        lock = '0;
    endtask

    task automatic test_lock_no_req();
        do_reset();
        lock = 4'b1111;
        req  = 4'b0000;
        settle();
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL lock_no_req_gnt got %b exp 0000", gnt); end
        step();
        lock = '0;
        req  = 4'b0101;
        settle();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL lock_no_req_busy got %b exp 0", busy); end
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL lock_no_req_gnt_a got %b exp 0001", gnt); end
        step();
        settle();
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL lock_no_req_gnt_b got %b exp 0100", gnt); end
        step();
        req = '0;
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        set_addr(0, 14'd55);
        req = 4'b0001;
        settle();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL midrst_gnt got %b exp 0001", gnt); end
        step();
        req = '0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bram_en !== 1'b0) begin errors++; $display("FAIL midrst_bram_en got %b exp 0", bram_en); end
        rst = 1'b0;
        step();
        settle();
        checks++;
        if (rvalid !== '0) begin errors++; $display("FAIL midrst_rvalid got %b exp 0000", rvalid); end
        checks++;
        if (bram_en !== 1'b0) begin errors++; $display("FAIL midrst_bram_en_after got %b exp 0", bram_en); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back_lat3();
        logic [NR-1:0] exp_v;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req3 = (i < 4) ? 4'b0100 : 4'b0000;
            addr3[2*AW +: AW] = AW'(300 + i);
            settle();
            if (i < 4) begin
                checks++;
                if (gnt3 !== 4'b0100) begin errors++; $display("FAIL lat3_gnt[%0d] got %b exp 0100", i, gnt3); end
            end
            if (i >= 3) begin
                exp_v = (i >= 4 && i <= 7) ? 4'b0100 : 4'b0000;
                checks++;
                if (rvalid3 !== exp_v) begin errors++; $display("FAIL lat3_rvalid[%0d] got %b exp %b", i, rvalid3, exp_v); end
                if (exp_v != 4'b0000) begin
                    checks++;
                    if (rdata3 !== fdata(AW'(300 + i - 4))) begin
                        errors++;
                        $display("FAIL lat3_rdata[%0d] got %h exp %h", i, rdata3, fdata(AW'(300 + i - 4)));
                    end
                end
            end
            step();
        end
    endtask

`ifdef MATRIX_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        settle();
        checks++;
        if (conflict_count !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d exp 0", conflict_count); end
        req = 4'b1011;
        repeat (3) step();
        req = '0;
        settle();
        checks++;
        if (conflict_count !== 16'd3) begin errors++; $display("FAIL stats_count got %0d exp 3", conflict_count); end
        req = 4'b1111;
        repeat (70000) @(posedge clk);
        #2;
        req = '0;
        settle();
        checks++;
        if (conflict_count !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate got %h exp ffff", conflict_count); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        lock  = '0;
        addr  = '0;
        req3  = '0;
        lock3 = '0;
        addr3 = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_lock_no_req();
        test_reset_mid_flight();
        test_back_to_back_lat3();
`ifdef MATRIX_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
